// File: rtl/dm_arbiter.sv
// Two-core data-memory arbiter: round-robin per access, optional bounded lock
// for bursts, registered memory drive and a one-cycle read-valid return.
module dm_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 17,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, ISSUE, RETURN} state_t;

  state_t           state, state_nxt;
  logic             owner_vld;
  logic             owner_id;
  logic             last;
  logic [CNT_W-1:0] burst_cnt;

  logic elig0_p0, elig1_p0, hold_p0, own_elig_p0, own_lock_p0;
  logic sel0_p0, sel1_p0, sel_any_p0, sel_lock_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= BURST_MAX) ? BURST_MAX : c + CNT_W'(1);
  endfunction

  assign rdata = mem_rdata;

  // Stage p0: pick a winner from this edge's requests, masking whoever holds gnt
  always_comb begin
    elig0_p0    = req0 & ~gnt0;
    elig1_p0    = req1 & ~gnt1;
    hold_p0     = owner_vld & (burst_cnt < BURST_MAX);
    own_elig_p0 = owner_id ? elig1_p0 : elig0_p0;
    own_lock_p0 = owner_id ? lock1 : lock0;
    sel0_p0     = 1'b0;
    sel1_p0     = 1'b0;
    if (hold_p0 && own_elig_p0) begin
      sel0_p0 = ~owner_id;
      sel1_p0 = owner_id;
    end else if (!(hold_p0 && own_lock_p0)) begin
      if (elig0_p0 && elig1_p0) begin
        sel0_p0 = last;
        sel1_p0 = ~last;
      end else begin
        sel0_p0 = elig0_p0;
        sel1_p0 = elig1_p0;
      end
    end
    sel_any_p0  = sel0_p0 | sel1_p0;
    sel_lock_p0 = (sel0_p0 & lock0) | (sel1_p0 & lock1);
  end

  // Stage p1: registered grant, memory drive, read return and lock bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last      <= 1'b1;
      owner_vld <= 1'b0;
      owner_id  <= 1'b0;
      burst_cnt <= '0;
    end else begin
      gnt0    <= sel0_p0;
      gnt1    <= sel1_p0;
      rvalid0 <= gnt0 & ~mem_we;
      rvalid1 <= gnt1 & ~mem_we;
      mem_we  <= (sel0_p0 & we0) | (sel1_p0 & we1);
      if (sel0_p0) begin
        mem_addr  <= addr0;
        mem_wdata <= wdata0;
        last      <= 1'b0;
      end else if (sel1_p0) begin
        mem_addr  <= addr1;
        mem_wdata <= wdata1;
        last      <= 1'b1;
      end
      if (sel_any_p0) begin
        if (sel_lock_p0) begin
          owner_vld <= 1'b1;
          owner_id  <= sel1_p0;
          burst_cnt <= (owner_vld && (owner_id == sel1_p0)) ? sat_inc(burst_cnt) : CNT_W'(1);
        end else begin
          owner_vld <= 1'b0;
          burst_cnt <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (sel_any_p0)                   state_nxt = ISSUE;
    else if ((gnt0 | gnt1) & ~mem_we) state_nxt = RETURN;
  end

  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_dm_arbiter;

  localparam int MAXB = 4;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [11:0] addr0, addr1;
  logic [16:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
  logic [16:0] rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;

  int n_checks = 0;
  int n_fail   = 0;

  dm_arbiter #(.ADDR_W(12), .DATA_W(17), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [16:0] init_word(input logic [11:0] a);
    if (a == 12'h010) return 17'h1ABCD;
    return {5'h0, a} ^ 17'h0A5A5;
  endfunction

  // Synchronous memory: address sampled at an edge, data out after that edge
  logic [16:0] mem [4096];
  bit          wr  [4096];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr[mem_addr]  <= 1'b1;
    end
    mem_rdata <= wr[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: who wins each edge, what memory holds, what comes back
  logic        m_gnt [2];
  logic        m_rv  [2];
  logic        m_we;
  logic [11:0] m_addr;
  logic [16:0] m_wdata, m_rdata, m_rd_val;
  int          m_last, m_owner, m_run, m_rd_who;
  logic [16:0] mdl_mem [logic [11:0]];

  task automatic model_reset();
    m_gnt[0] = 1'b0; m_gnt[1] = 1'b0;
    m_rv[0]  = 1'b0; m_rv[1]  = 1'b0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_rd_val = '0;
    m_last = 1; m_owner = -1; m_run = 0; m_rd_who = -1;
  endtask

  initial begin
    bit want [2];
    bit lk   [2];
    int w;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        if (m_rd_who >= 0) begin
          m_rv[1'(m_rd_who)] = 1'b1;
          m_rdata = m_rd_val;
        end
        m_rd_who = -1;
        want[0] = req0 && !m_gnt[0];
        want[1] = req1 && !m_gnt[1];
        lk[0] = lock0;
        lk[1] = lock1;
        w = -1;
        if (m_owner >= 0 && m_run < MAXB && want[1'(m_owner)]) w = m_owner;
        else if (m_owner >= 0 && m_run < MAXB && lk[1'(m_owner)]) w = -1;
        else if (want[0] && want[1]) w = 1 - m_last;
        else if (want[0]) w = 0;
        else if (want[1]) w = 1;
        m_gnt[0] = 1'b0; m_gnt[1] = 1'b0; m_we = 1'b0;
        if (w >= 0) begin
          m_gnt[1'(w)] = 1'b1;
          m_last  = w;
          m_we    = (w == 1) ? we1 : we0;
          m_addr  = (w == 1) ? addr1 : addr0;
          m_wdata = (w == 1) ? wdata1 : wdata0;
          if (m_we) mdl_mem[m_addr] = m_wdata;
          else begin
            m_rd_who = w;
            m_rd_val = mdl_mem.exists(m_addr) ? mdl_mem[m_addr] : init_word(m_addr);
          end
          if (lk[1'(w)]) begin
            m_run   = (m_owner == w) ? ((m_run < MAXB) ? m_run + 1 : MAXB) : 1;
            m_owner = w;
          end else begin
            m_owner = -1;
            m_run   = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("m_gnt0", 32'(gnt0), 32'(m_gnt[0]));
      check("m_gnt1", 32'(gnt1), 32'(m_gnt[1]));
      check("m_rvalid0", 32'(rvalid0), 32'(m_rv[0]));
      check("m_rvalid1", 32'(rvalid1), 32'(m_rv[1]));
      check("m_mem_we", 32'(mem_we), 32'(m_we));
      check("m_mem_addr", 32'(mem_addr), 32'(m_addr));
      check("m_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      check("m_busy", 32'(busy), 32'(m_gnt[0] | m_gnt[1] | m_rv[0] | m_rv[1]));
      check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
      if (m_rv[0] || m_rv[1]) check("m_rdata", 32'(rdata), 32'(m_rdata));
    end
  end

  initial begin
    int g0, first1;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Single read by core0
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
    @(posedge clk); #1;
    check("rd_gnt0", 32'(gnt0), 32'd1);
    check("rd_mem_addr", 32'(mem_addr), 32'h010);
    @(negedge clk) req0 = 1'b0;
    @(posedge clk); #1;
    check("rd_rvalid0", 32'(rvalid0), 32'd1);
    check("rd_rdata", 32'(rdata), 32'h1ABCD);
    check("rd_busy_mid", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("rd_busy_end", 32'(busy), 32'd0);

    // Single write by core1, then read it back through core0
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h0FF; wdata1 = 17'h00055;
    @(posedge clk); #1;
    check("wr_gnt1", 32'(gnt1), 32'd1);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    req1 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h0FF;
    @(posedge clk); #1;
    check("wr_we_one_cycle", 32'(mem_we), 32'd0);
    check("wr_no_rvalid1", 32'(rvalid1), 32'd0);
    check("rb_gnt0", 32'(gnt0), 32'd1);
    @(negedge clk) req0 = 1'b0;
    @(posedge clk); #1;
    check("rb_rvalid0", 32'(rvalid0), 32'd1);
    check("rb_rdata", 32'(rdata), 32'h00055);

    // Both held after reset: strict alternation starting with core0
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 12'h100; addr1 = 12'h200;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("alt_gnt0", 32'(gnt0), 32'((i % 2) == 0));
      check("alt_gnt1", 32'(gnt1), 32'((i % 2) == 1));
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Locked burst by core0 while core1 waits
    req0 = 1'b1; lock0 = 1'b1; addr0 = 12'h020;
    req1 = 1'b1; addr1 = 12'h030;
    g0 = 0; first1 = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (gnt1 && first1 == 0) first1 = e;
      if (gnt0 && first1 == 0) g0++;
      @(negedge clk);
      if (first1 != 0) begin
        req0 = 1'b0; lock0 = 1'b0; req1 = 1'b0;
      end
    end
    check("burst_core0_grants", 32'(g0), 32'd4);
    check("burst_core1_edge", 32'(first1), 32'd8);
    repeat (2) @(negedge clk);

    // Reset between a read grant and its return
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
    @(posedge clk); #1;
    check("mr_gnt0", 32'(gnt0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_gnt0_clr", 32'(gnt0), 32'd0);
    check("mr_mem_addr_clr", 32'(mem_addr), 32'd0);
    check("mr_mem_we_clr", 32'(mem_we), 32'd0);
    check("mr_busy_clr", 32'(busy), 32'd0);
    check("mr_rvalid0_clr", 32'(rvalid0), 32'd0);
    @(negedge clk) req0 = 1'b0;
    @(posedge clk); #1;
    check("mr_no_rvalid0", 32'(rvalid0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 12'h040; addr1 = 12'h050;
    @(posedge clk); #1;
    check("mr_tie_gnt0", 32'(gnt0), 32'd1);
    check("mr_tie_gnt1", 32'(gnt1), 32'd0);
    check("mr_no_rvalid0_rel", 32'(rvalid0), 32'd0);
    @(negedge clk) req0 = 1'b0;
    @(posedge clk); #1;
    check("mr_next_gnt1", 32'(gnt1), 32'd1);
    @(negedge clk) req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Masking: a continuously held request is granted every second edge
    req0 = 1'b1; addr0 = 12'h060;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("mask_gnt0", 32'(gnt0), 32'((i % 2) == 0));
    end
    @(negedge clk) req0 = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
